// File: rtl/alu_pkg.sv
// ============================================================================
//  alu_pkg
//  Shared definitions for the ALU operation sequencer: FSM state encoding,
//  ALU flag bit positions and 5-bit ALU opcode constants.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Sequencer FSM state encoding
  localparam int         ST_W    = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ALU flag vector layout: {aux_carry, carry, overflow, parity, sign, zero}
  localparam int FLAG_W         = 6;
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_SIGN      = 1;
  localparam int FLAG_PARITY    = 2;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_CARRY     = 4;
  localparam int FLAG_AUX_CARRY = 5;

  // ALU opcodes
  localparam int         OP_W   = 5;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_ADC = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_SBB = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;

endpackage

`default_nettype wire

// File: rtl/alu_lat_counter.sv
// ============================================================================
//  alu_lat_counter
//  Loadable down-counter that times the ALU result latency. Saturates at 0.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_lat_counter #(
  parameter int CW = 4
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          is_zero
);

  logic [CW-1:0] count;

  // Load takes priority over decrement; never wraps below zero
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign is_zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  alu_op_sequencer
//  Accepts one ALU command at a time, drives registered operands to an
//  external ALU, waits LATENCY edges, captures result/flags and presents
//  them on a valid/ready response port. Keeps a chain carry for multi-word
//  arithmetic.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int LATENCY = 2,  // ALU result latency in edges, legal 1..15
  parameter int W       = 8
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_sel,
  input  logic signed [W-1:0] cmd_a,
  input  logic signed [W-1:0] cmd_b,
  input  logic                cmd_carry,
  input  logic                cmd_chain,
  // ALU drive and return
  output logic [OP_W-1:0]     alu_sel,
  output logic signed [W-1:0] alu_in_1,
  output logic signed [W-1:0] alu_in_2,
  output logic                alu_in_carry,
  input  logic [W-1:0]        alu_out,
  input  logic [FLAG_W-1:0]   alu_flags,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_result,
  output logic [FLAG_W-1:0]   rsp_flags,
  output logic                carry_q
);

  localparam int             CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [ST_W-1:0] state;
  logic            cmd_fire;
  logic            capture;
  logic            rsp_done;
  logic            cnt_zero;

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign cmd_fire  = cmd_valid && cmd_ready;
  // The counter holds LATENCY-1 at accept, so reaching zero in WAIT marks
  // the edge on which the ALU result is valid.
  assign capture   = (state == ST_WAIT) && cnt_zero;
  assign rsp_done  = rsp_valid && rsp_ready;

  alu_lat_counter #(
    .CW (CNT_W)
  ) u_lat_counter (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .load     (cmd_fire),
    .load_val (CNT_LOAD),
    .dec      (state == ST_WAIT),
    .is_zero  (cnt_zero)
  );

  // Sequencer FSM: IDLE -> WAIT -> RESP -> IDLE
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cmd_fire) state <= ST_WAIT;
        ST_WAIT: if (capture)  state <= ST_RESP;
        ST_RESP: if (rsp_done) state <= ST_IDLE;
        default:               state <= ST_IDLE;
      endcase
    end
  end

  // ALU drive registers: loaded on accept, held until the next accept
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      alu_sel      <= '0;
      alu_in_1     <= '0;
      alu_in_2     <= '0;
      alu_in_carry <= 1'b0;
    end else if (cmd_fire) begin
      alu_sel      <= cmd_sel;
      alu_in_1     <= cmd_a;
      alu_in_2     <= cmd_b;
      alu_in_carry <= cmd_chain ? carry_q : cmd_carry;
    end
  end

  // Result capture and chain-carry update on the capture edge
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
      carry_q    <= 1'b0;
    end else if (capture) begin
      rsp_result <= alu_out;
      rsp_flags  <= alu_flags;
      carry_q    <= alu_flags[FLAG_CARRY];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
//  tb_alu_op_sequencer
//  Directed self-checking bench. Two sequencers (LATENCY=2 and LATENCY=1),
//  each paired with a behavioural ALU whose pipeline depth is LATENCY-1, so
//  an early capture would see stale data.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // ---------------- LATENCY = 2 instance signals ----------------
  logic       d2_cmd_valid = 1'b0, d2_cmd_ready;
  logic [4:0] d2_cmd_sel = '0;
  logic [7:0] d2_cmd_a = '0, d2_cmd_b = '0;
  logic       d2_cmd_carry = 1'b0, d2_cmd_chain = 1'b0;
  logic [4:0] d2_alu_sel;
  logic [7:0] d2_alu_in_1, d2_alu_in_2, d2_alu_out;
  logic       d2_alu_in_carry;
  logic [5:0] d2_alu_flags;
  logic       d2_rsp_valid, d2_rsp_ready = 1'b0;
  logic [7:0] d2_rsp_result;
  logic [5:0] d2_rsp_flags;
  logic       d2_carry_q;

  // ---------------- LATENCY = 1 instance signals ----------------
  logic       d1_cmd_valid = 1'b0, d1_cmd_ready;
  logic [4:0] d1_cmd_sel = '0;
  logic [7:0] d1_cmd_a = '0, d1_cmd_b = '0;
  logic       d1_cmd_carry = 1'b0, d1_cmd_chain = 1'b0;
  logic [4:0] d1_alu_sel;
  logic [7:0] d1_alu_in_1, d1_alu_in_2, d1_alu_out;
  logic       d1_alu_in_carry;
  logic [5:0] d1_alu_flags;
  logic       d1_rsp_valid, d1_rsp_ready = 1'b0;
  logic [7:0] d1_rsp_result;
  logic [5:0] d1_rsp_flags;
  logic       d1_carry_q;

  alu_op_sequencer #(.LATENCY(2), .W(8)) u_dut2 (
    .in_clk(clk), .in_rst_n(rst_n),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_sel(d2_cmd_sel),
    .cmd_a(d2_cmd_a), .cmd_b(d2_cmd_b), .cmd_carry(d2_cmd_carry), .cmd_chain(d2_cmd_chain),
    .alu_sel(d2_alu_sel), .alu_in_1(d2_alu_in_1), .alu_in_2(d2_alu_in_2),
    .alu_in_carry(d2_alu_in_carry), .alu_out(d2_alu_out), .alu_flags(d2_alu_flags),
    .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_result(d2_rsp_result),
    .rsp_flags(d2_rsp_flags), .carry_q(d2_carry_q)
  );

  alu_op_sequencer #(.LATENCY(1), .W(8)) u_dut1 (
    .in_clk(clk), .in_rst_n(rst_n),
    .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_sel(d1_cmd_sel),
    .cmd_a(d1_cmd_a), .cmd_b(d1_cmd_b), .cmd_carry(d1_cmd_carry), .cmd_chain(d1_cmd_chain),
    .alu_sel(d1_alu_sel), .alu_in_1(d1_alu_in_1), .alu_in_2(d1_alu_in_2),
    .alu_in_carry(d1_alu_in_carry), .alu_out(d1_alu_out), .alu_flags(d1_alu_flags),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_result(d1_rsp_result),
    .rsp_flags(d1_rsp_flags), .carry_q(d1_carry_q)
  );

  // Behavioural ALU: returns {flags[5:0], result[7:0]}; parity is even parity
  function automatic logic [13:0] alu_model(input logic [4:0] sel, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
    logic [8:0] t;
    logic [4:0] n;
    logic [7:0] r;
    logic       c, ov, sub;
    sub = (sel == OP_SUB) || (sel == OP_SBB);
    c   = ((sel == OP_ADC) || (sel == OP_SBB)) ? cin : 1'b0;
    if (sub) begin
      t = {1'b0, a} - {1'b0, b} - {8'b0, c};
      n = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, c};
    end else begin
      t = {1'b0, a} + {1'b0, b} + {8'b0, c};
      n = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c};
    end
    r  = t[7:0];
    ov = sub ? ((a[7] != b[7]) && (r[7] != a[7])) : ((a[7] == b[7]) && (r[7] != a[7]));
    return {n[4], t[8], ov, ~^r, r[7], (r == 8'h00), r};
  endfunction

  // LATENCY=2 ALU: one register stage
  logic [13:0] d2_pipe;
  always @(posedge clk) d2_pipe <= alu_model(d2_alu_sel, d2_alu_in_1, d2_alu_in_2, d2_alu_in_carry);
  assign {d2_alu_flags, d2_alu_out} = d2_pipe;

  // LATENCY=1 ALU: purely combinational
  assign {d1_alu_flags, d1_alu_out} = alu_model(d1_alu_sel, d1_alu_in_1, d1_alu_in_2, d1_alu_in_carry);

  // Present a command to the LATENCY=2 DUT for one edge (DUT assumed idle)
  task automatic send2(input logic [4:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic ch);
    @(negedge clk);
    d2_cmd_sel = sel; d2_cmd_a = a; d2_cmd_b = b; d2_cmd_carry = c; d2_cmd_chain = ch;
    d2_cmd_valid = 1'b1;
    @(posedge clk); #1;
    d2_cmd_valid = 1'b0;
  endtask

  // Complete the response handshake on the next edge
  task automatic ack2();
    d2_rsp_ready = 1'b1;
    @(posedge clk); #1;
    d2_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (d2_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", d2_rsp_valid); end
    vectors++; if (d2_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", d2_cmd_ready); end
    vectors++; if ({d2_alu_sel, d2_alu_in_1, d2_alu_in_2, d2_alu_in_carry} !== 22'h0) begin miscompares++; $display("FAIL reset_alu: got %h/%h/%h/%b want 0", d2_alu_sel, d2_alu_in_1, d2_alu_in_2, d2_alu_in_carry); end
    vectors++; if ({d2_rsp_result, d2_rsp_flags, d2_carry_q} !== 15'h0) begin miscompares++; $display("FAIL reset_rsp: got %h/%h/%b want 0", d2_rsp_result, d2_rsp_flags, d2_carry_q); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ADC 0x7F + 0x09 + 1, with exact latency check
  task automatic test_adc_latency();
    send2(OP_ADC, 8'h7F, 8'h09, 1'b1, 1'b0);
    @(negedge clk);
    vectors++; if ({d2_alu_sel, d2_alu_in_1, d2_alu_in_2, d2_alu_in_carry} !== {5'b00001, 8'h7F, 8'h09, 1'b1}) begin miscompares++; $display("FAIL adc_alu_drive: got %h/%h/%h/%b want 01/7f/09/1", d2_alu_sel, d2_alu_in_1, d2_alu_in_2, d2_alu_in_carry); end
    vectors++; if ({d2_cmd_ready, d2_rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL adc_wait0: got ready=%b valid=%b want 0 0", d2_cmd_ready, d2_rsp_valid); end
    @(negedge clk);
    vectors++; if (d2_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL adc_early_valid: got %b want 0", d2_rsp_valid); end
    @(negedge clk);
    vectors++; if (d2_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL adc_valid: got %b want 1", d2_rsp_valid); end
    vectors++; if (d2_rsp_result !== 8'h89) begin miscompares++; $display("FAIL adc_result: got %h want 89", d2_rsp_result); end
    vectors++; if (d2_rsp_flags !== 6'b101010) begin miscompares++; $display("FAIL adc_flags: got %b want 101010", d2_rsp_flags); end
    vectors++; if (d2_carry_q !== 1'b0) begin miscompares++; $display("FAIL adc_carry_q: got %b want 0", d2_carry_q); end
    ack2();
    @(negedge clk);
    vectors++; if ({d2_cmd_ready, d2_rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL adc_return_idle: got ready=%b valid=%b want 1 0", d2_cmd_ready, d2_rsp_valid); end
  endtask

  // ADD 0xFF+0x01 sets carry; chained ADC 0+0 then consumes it
  task automatic test_chain();
    send2(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (d2_rsp_result !== 8'h00) begin miscompares++; $display("FAIL chain1_result: got %h want 00", d2_rsp_result); end
    vectors++; if (d2_rsp_flags !== 6'b110101) begin miscompares++; $display("FAIL chain1_flags: got %b want 110101", d2_rsp_flags); end
    vectors++; if (d2_carry_q !== 1'b1) begin miscompares++; $display("FAIL chain1_carry_q: got %b want 1", d2_carry_q); end
    ack2();
    send2(OP_ADC, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    vectors++; if (d2_alu_in_carry !== 1'b1) begin miscompares++; $display("FAIL chain2_alu_in_carry: got %b want 1", d2_alu_in_carry); end
    repeat (2) @(negedge clk);
    vectors++; if (d2_rsp_result !== 8'h01) begin miscompares++; $display("FAIL chain2_result: got %h want 01", d2_rsp_result); end
    vectors++; if (d2_rsp_flags !== 6'b000000) begin miscompares++; $display("FAIL chain2_flags: got %b want 000000", d2_rsp_flags); end
    vectors++; if (d2_carry_q !== 1'b0) begin miscompares++; $display("FAIL chain2_carry_q: got %b want 0", d2_carry_q); end
    ack2();
  endtask

  // SUB 0x00-0x01 -> 0xFF with borrow
  task automatic test_sub();
    send2(OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (d2_rsp_result !== 8'hFF) begin miscompares++; $display("FAIL sub_result: got %h want ff", d2_rsp_result); end
    vectors++; if (d2_rsp_flags !== 6'b110110) begin miscompares++; $display("FAIL sub_flags: got %b want 110110", d2_rsp_flags); end
    vectors++; if (d2_carry_q !== 1'b1) begin miscompares++; $display("FAIL sub_carry_q: got %b want 1", d2_carry_q); end
    ack2();
  endtask

  // Response held under rsp_ready=0 while another command is offered
  task automatic test_backpressure();
    send2(OP_ADC, 8'h12, 8'h34, 1'b1, 1'b0);
    d2_cmd_sel = OP_ADD; d2_cmd_a = 8'hAA; d2_cmd_b = 8'h55; d2_cmd_carry = 1'b0;
    d2_cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++; if ({d2_rsp_valid, d2_cmd_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_handshake[%0d]: got valid=%b ready=%b want 1 0", i, d2_rsp_valid, d2_cmd_ready); end
      vectors++; if ({d2_rsp_result, d2_rsp_flags} !== {8'h47, 6'b000100}) begin miscompares++; $display("FAIL bp_payload[%0d]: got %h/%b want 47/000100", i, d2_rsp_result, d2_rsp_flags); end
      vectors++; if (d2_alu_in_1 !== 8'h12) begin miscompares++; $display("FAIL bp_alu_hold[%0d]: got %h want 12", i, d2_alu_in_1); end
    end
    ack2();
    d2_cmd_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({d2_cmd_ready, d2_rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_no_same_edge_accept: got ready=%b valid=%b want 1 0", d2_cmd_ready, d2_rsp_valid); end
    vectors++; if (d2_alu_in_1 !== 8'h12) begin miscompares++; $display("FAIL bp_alu_after: got %h want 12", d2_alu_in_1); end
  endtask

  // Asynchronous reset in WAIT aborts the operation
  task automatic test_reset_mid_wait();
    send2(OP_ADD, 8'h5A, 8'h21, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({d2_alu_sel, d2_alu_in_1, d2_alu_in_2, d2_alu_in_carry} !== 22'h0) begin miscompares++; $display("FAIL rst_wait_alu: got %h/%h/%h/%b want 0", d2_alu_sel, d2_alu_in_1, d2_alu_in_2, d2_alu_in_carry); end
    vectors++; if ({d2_rsp_valid, d2_rsp_result, d2_rsp_flags, d2_carry_q} !== 16'h0) begin miscompares++; $display("FAIL rst_wait_rsp: got %b/%h/%b/%b want 0", d2_rsp_valid, d2_rsp_result, d2_rsp_flags, d2_carry_q); end
    vectors++; if (d2_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wait_idle: got %b want 1", d2_cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if ({d2_rsp_valid, d2_cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL rst_no_resp[%0d]: got valid=%b ready=%b want 0 1", i, d2_rsp_valid, d2_cmd_ready); end
    end
    send2(OP_ADD, 8'h03, 8'h04, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++; if ({d2_rsp_valid, d2_rsp_result, d2_rsp_flags} !== {1'b1, 8'h07, 6'b000000}) begin miscompares++; $display("FAIL rst_recover: got %b/%h/%b want 1/07/000000", d2_rsp_valid, d2_rsp_result, d2_rsp_flags); end
    ack2();
  endtask

  // LATENCY=1, commands always offered, rsp_ready held 1
  task automatic test_back_to_back();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic [7:0] te [4];
    int idx, nresp, last;
    logic acc;
    ta[0] = 8'h10; tb[0] = 8'h01; te[0] = 8'h11;
    ta[1] = 8'h20; tb[1] = 8'h02; te[1] = 8'h22;
    ta[2] = 8'h7F; tb[2] = 8'h01; te[2] = 8'h80;
    ta[3] = 8'hF0; tb[3] = 8'h20; te[3] = 8'h10;
    idx = 0; nresp = 0; last = 0;
    d1_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
      @(negedge clk);
      if (d1_rsp_valid === 1'b1) begin
        vectors++; if (d1_rsp_result !== te[nresp]) begin miscompares++; $display("FAIL b2b_result[%0d]: got %h want %h", nresp, d1_rsp_result, te[nresp]); end
        if (nresp > 0) begin
          vectors++; if (cyc - last != 3) begin miscompares++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", nresp, cyc - last); end
        end
        last = cyc;
        nresp++;
      end
      if (idx < 4) begin
        d1_cmd_sel = OP_ADD; d1_cmd_a = ta[idx]; d1_cmd_b = tb[idx]; d1_cmd_valid = 1'b1;
      end else begin
        d1_cmd_valid = 1'b0;
      end
      acc = d1_cmd_valid && d1_cmd_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    d1_cmd_valid = 1'b0;
    vectors++; if (nresp != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", nresp); end
    @(negedge clk);
    vectors++; if (d1_carry_q !== 1'b1) begin miscompares++; $display("FAIL b2b_carry_q: got %b want 1", d1_carry_q); end
    d1_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_adc_latency();
    test_chain();
    test_sub();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
